serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 150 +++++++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor. A single registered full-adder cell processes
//   one operand bit per clock, LSB first. An operation is started from IDLE or
//   DONE, runs for WIDTH cycles in SHIFT and presents its result for one cycle
//   in DONE, where a new start can be taken back-to-back.
//
// Ports
//   clk    in   1      single clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      begin an operation (honoured in IDLE or DONE only)
//   sub    in   1      0 = a + b + cin, 1 = a - b
//   a      in   WIDTH  first operand
//   b      in   WIDTH  second operand
//   cin    in   1      carry-in, add mode only
//   busy   out  1      high while bits are being processed (SHIFT)
//   done   out  1      one-cycle pulse marking a new result
//   sum    out  WIDTH  result register, held between operations
//   cout   out  1      carry-out of the MSB (subtract: 1 = no borrow)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter holds 0..WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             bit_sum_s;
    logic             bit_carry_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] acc_next_s;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Full-adder cell on the current LSBs; the new sum bit enters the
    // accumulator at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
    always_comb begin
        bit_sum_s   = 1'b0;
        bit_carry_s = 1'b0;
        last_bit_s  = 1'b0;
        acc_next_s  = '0;
        bit_sum_s   = fa_sum(a_r[0], b_r[0], carry_r);
        bit_carry_s = fa_carry(a_r[0], b_r[0], carry_r);
        if (cnt_r == CW'(WIDTH - 1)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
        acc_next_s  = WIDTH'({bit_sum_s, acc_r} >> 1'b1);
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b and seed carry with 1.
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    a_r     <= a_r >> 1'b1;
                    b_r     <= b_r >> 1'b1;
                    carry_r <= bit_carry_s;
                    acc_r   <= acc_next_s;
                    cnt_r   <= cnt_r + 1'b1;
                    if (last_bit_s) begin
                        sum_r   <= acc_next_s;
                        cout_r  <= bit_carry_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, sub, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1, a1, b1, cin1;
    logic       busy1, done1, cout1, sum1;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    logic [8:0] sb[$];
    logic [7:0] prev_sum;
    logic       prev_cout;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(1'b0), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Run one operation, checking latency, busy length, result hold and result.
    task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic isub, input logic icin, input bit disturb);
        logic [8:0] e;
        int         busy_n, lat;
        bit         hold_ok, got;
        e = {1'b0, ia} + {1'b0, (isub ? ~ib : ib)} + (isub ? 9'd1 : {8'd0, icin});
        sb.push_back(e);
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sub = ~isub; cin = ~icin;
        lat = 1; busy_n = 0; hold_ok = 1'b1; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            if (sum !== prev_sum || cout !== prev_cout) hold_ok = 1'b0;
            if (disturb && k == 2) begin
                start = 1'b1; a = 8'h11;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'd9);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd8);
        chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        e = sb.pop_front();
        chk({tag, "_sum"}, 64'(sum), 64'(e[7:0]));
        chk({tag, "_cout"}, 64'(cout), 64'(e[8]));
        prev_sum = e[7:0]; prev_cout = e[8];
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [8:0] e;
        bit         got;
        int         n0, t1, t2;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        prev_sum = 8'h00; prev_cout = 1'b0;

        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0, 1'b0);
        do_op("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b1, 1'b0);
        do_op("add_cin", 8'h7F, 8'h80, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        // Start and new operands mid-operation must be ignored.
        n0 = done_cnt;
        do_op("ignore", 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        repeat (12) tick();
        chk("ignore_single_done", 64'(done_cnt - n0), 64'd1);
        chk("ignore_sum_kept", 64'(sum), 64'h30);

        // Back-to-back: start held through DONE.
        sb.push_back(9'h002);
        sb.push_back(9'h100);
        a = 8'h01; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        a = 8'h80; b = 8'h80;
        wait_done(got);
        t1 = cyc;
        chk("b2b_first_done", 64'(got), 64'd1);
        e = sb.pop_front();
        chk("b2b_first_sum", 64'(sum), 64'(e[7:0]));
        chk("b2b_first_cout", 64'(cout), 64'(e[8]));
        tick();
        start = 1'b0;
        chk("b2b_restart_busy", 64'(busy), 64'd1);
        chk("b2b_restart_done", 64'(done), 64'd0);
        wait_done(got);
        t2 = cyc;
        chk("b2b_second_done", 64'(got), 64'd1);
        chk("b2b_spacing", 64'(t2 - t1), 64'd9);
        e = sb.pop_front();
        chk("b2b_second_sum", 64'(sum), 64'(e[7:0]));
        chk("b2b_second_cout", 64'(cout), 64'(e[8]));
        tick();

        // Reset at E4 discards the operation.
        a = 8'hAA; b = 8'h55; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        n0 = done_cnt;
        repeat (12) tick();
        chk("midrst_no_done", 64'(done_cnt - n0), 64'd0);

        // Start together with reset is ignored.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        tick();
        chk("rst_start_busy2", 64'(busy), 64'd0);
        chk("rst_start_done", 64'(done), 64'd0);

        // WIDTH=1 instance.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("w1_busy", 64'(busy1), 64'd1);
        chk("w1_done_early", 64'(done1), 64'd0);
        tick();
        chk("w1_done", 64'(done1), 64'd1);
        chk("w1_sum", 64'(sum1), 64'd1);
        chk("w1_cout", 64'(cout1), 64'd1);
        tick();
        chk("w1_done_pulse", 64'(done1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
